// File: rtl/accel_bcd_converter_pkg.sv
// Shared constants for the accelerometer binary-to-BCD converter:
// FSM state encodings, axis indices and the BCD nibble width.
package accel_bcd_converter_pkg;

    localparam int BCD_NIB_W = 4;
    localparam int N_AXES    = 3;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE  = 3'd0;
    localparam state_t ST_LOAD  = 3'd1;
    localparam state_t ST_SHIFT = 3'd2;
    localparam state_t ST_NEXT  = 3'd3;
    localparam state_t ST_DONE  = 3'd4;

    localparam logic [1:0] AXIS_X = 2'd0;
    localparam logic [1:0] AXIS_Y = 2'd1;
    localparam logic [1:0] AXIS_Z = 2'd2;

endpackage

// File: rtl/accel_bcd_converter_bcd_add3_adjust.sv
// Double-dabble correction cell: every BCD nibble that is 5 or more gets 3 added
// so that the following left shift carries correctly into the next digit.
module bcd_add3_adjust
    import accel_bcd_converter_pkg::*;
#(
    parameter int DIGITS = 5
) (
    input  logic [BCD_NIB_W*DIGITS-1:0] i_bcd,
    output logic [BCD_NIB_W*DIGITS-1:0] o_bcd
);

    always_comb begin
        o_bcd = i_bcd;
        for (int d = 0; d < DIGITS; d++) begin
            if (i_bcd[d*BCD_NIB_W +: BCD_NIB_W] >= 4'd5) begin
                o_bcd[d*BCD_NIB_W +: BCD_NIB_W] = i_bcd[d*BCD_NIB_W +: BCD_NIB_W] + 4'd3;
            end
        end
    end

endmodule

// File: rtl/accel_bcd_converter.sv
// Sequential signed-binary-to-BCD converter for three accelerometer axes.
// Converts one axis at a time with shift-add-3 and publishes all axes atomically.
module accel_bcd_converter
    import accel_bcd_converter_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int DIGITS = 5,
    parameter int OVR_W  = 8
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          data_update,
    input  logic signed [DATA_W-1:0]      data_x,
    input  logic signed [DATA_W-1:0]      data_y,
    input  logic signed [DATA_W-1:0]      data_z,
    output logic [BCD_NIB_W*DIGITS-1:0]   bcd_x,
    output logic [BCD_NIB_W*DIGITS-1:0]   bcd_y,
    output logic [BCD_NIB_W*DIGITS-1:0]   bcd_z,
    output logic                          neg_x,
    output logic                          neg_y,
    output logic                          neg_z,
    output logic                          bcd_valid,
    output logic                          busy,
    output logic [OVR_W-1:0]              overrun_cnt
);

    localparam int BCD_W = BCD_NIB_W * DIGITS;
    localparam int CNT_W = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

    state_t                    r_state;
    logic [1:0]                r_axis;
    logic [CNT_W-1:0]          r_bitcnt;
    logic signed [DATA_W-1:0]  r_snap [N_AXES];
    logic signed [DATA_W-1:0]  r_pend [N_AXES];
    logic                      r_pend_vld;
    logic [BCD_W-1:0]          r_bcd;
    logic [DATA_W-1:0]         r_mag;
    logic                      r_neg;
    logic [BCD_W-1:0]          r_sh_bcd [N_AXES];
    logic                      r_sh_neg [N_AXES];
    logic [BCD_W-1:0]          r_out_bcd [N_AXES];
    logic                      r_out_neg [N_AXES];
    logic                      r_valid;
    logic [OVR_W-1:0]          r_ovr;

    logic                      w_busy;
    logic                      w_start;
    logic signed [DATA_W-1:0]  w_sel;
    logic [DATA_W-1:0]         w_abs;
    logic [BCD_W-1:0]          w_adj;

    assign w_busy  = (r_state != ST_IDLE);
    assign w_start = !w_busy && (data_update || r_pend_vld);

    always_comb begin
        w_sel = r_snap[0];
        if (r_axis == AXIS_Y) begin
            w_sel = r_snap[1];
        end else if (r_axis == AXIS_Z) begin
            w_sel = r_snap[2];
        end
    end

    // Unsigned magnitude: the most negative sample maps to 2^(DATA_W-1) without overflow.
    assign w_abs = w_sel[DATA_W-1] ? (~$unsigned(w_sel) + 1'b1) : $unsigned(w_sel);

    bcd_add3_adjust #(
        .DIGITS (DIGITS)
    ) u_add3 (
        .i_bcd (r_bcd),
        .o_bcd (w_adj)
    );

    // Samples arriving while busy wait in a single-entry buffer; the newest one wins.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pend_vld <= 1'b0;
            r_ovr      <= '0;
            for (int i = 0; i < N_AXES; i++) begin
                r_pend[i] <= '0;
            end
        end else begin
            if (data_update && w_busy) begin
                r_pend[0]  <= data_x;
                r_pend[1]  <= data_y;
                r_pend[2]  <= data_z;
                r_pend_vld <= 1'b1;
            end else if (w_start) begin
                r_pend_vld <= 1'b0;
            end
            if (data_update && r_pend_vld && (r_ovr != '1)) begin
                r_ovr <= r_ovr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= ST_IDLE;
            r_axis   <= AXIS_X;
            r_bitcnt <= '0;
            r_bcd    <= '0;
            r_mag    <= '0;
            r_neg    <= 1'b0;
            r_valid  <= 1'b0;
            for (int i = 0; i < N_AXES; i++) begin
                r_snap[i]    <= '0;
                r_sh_bcd[i]  <= '0;
                r_sh_neg[i]  <= 1'b0;
                r_out_bcd[i] <= '0;
                r_out_neg[i] <= 1'b0;
            end
        end else begin
            r_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (data_update) begin
                        r_snap[0] <= data_x;
                        r_snap[1] <= data_y;
                        r_snap[2] <= data_z;
                    end else if (r_pend_vld) begin
                        for (int i = 0; i < N_AXES; i++) begin
                            r_snap[i] <= r_pend[i];
                        end
                    end
                    if (w_start) begin
                        r_axis  <= AXIS_X;
                        r_state <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    r_neg    <= w_sel[DATA_W-1];
                    r_mag    <= w_abs;
                    r_bcd    <= '0;
                    r_bitcnt <= '0;
                    r_state  <= ST_SHIFT;
                end
                ST_SHIFT: begin
                    r_bcd    <= (w_adj << 1) | BCD_W'(r_mag[DATA_W-1]);
                    r_mag    <= r_mag << 1;
                    r_bitcnt <= r_bitcnt + 1'b1;
                    if (r_bitcnt == LAST_BIT) begin
                        r_state <= ST_NEXT;
                    end
                end
                ST_NEXT: begin
                    for (int i = 0; i < N_AXES; i++) begin
                        if (r_axis == 2'(i)) begin
                            r_sh_bcd[i] <= r_bcd;
                            r_sh_neg[i] <= r_neg;
                        end
                    end
                    if (r_axis == AXIS_Z) begin
                        r_state <= ST_DONE;
                    end else begin
                        r_axis  <= r_axis + 1'b1;
                        r_state <= ST_LOAD;
                    end
                end
                ST_DONE: begin
                    for (int i = 0; i < N_AXES; i++) begin
                        r_out_bcd[i] <= r_sh_bcd[i];
                        r_out_neg[i] <= r_sh_neg[i];
                    end
                    r_valid <= 1'b1;
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bcd_x       = r_out_bcd[0];
    assign bcd_y       = r_out_bcd[1];
    assign bcd_z       = r_out_bcd[2];
    assign neg_x       = r_out_neg[0];
    assign neg_y       = r_out_neg[1];
    assign neg_z       = r_out_neg[2];
    assign bcd_valid   = r_valid;
    assign busy        = w_busy;
    assign overrun_cnt = r_ovr;

endmodule

// File: tb/tb_accel_bcd_converter.sv
// Directed bench for accel_bcd_converter: conversion values, latency, pending
// buffer behaviour, async reset mid-conversion and overrun saturation.
module tb_accel_bcd_converter;

    logic               clk;
    logic               reset_n;
    logic               data_update;
    logic signed [15:0] data_x;
    logic signed [15:0] data_y;
    logic signed [15:0] data_z;
    logic [19:0]        bcd_x;
    logic [19:0]        bcd_y;
    logic [19:0]        bcd_z;
    logic               neg_x;
    logic               neg_y;
    logic               neg_z;
    logic               bcd_valid;
    logic               busy;
    logic [7:0]         overrun_cnt;

    int n_chk  = 0;
    int n_pass = 0;

    accel_bcd_converter #(
        .DATA_W (16),
        .DIGITS (5),
        .OVR_W  (8)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .data_update (data_update),
        .data_x      (data_x),
        .data_y      (data_y),
        .data_z      (data_z),
        .bcd_x       (bcd_x),
        .bcd_y       (bcd_y),
        .bcd_z       (bcd_z),
        .neg_x       (neg_x),
        .neg_y       (neg_y),
        .neg_z       (neg_z),
        .bcd_valid   (bcd_valid),
        .busy        (busy),
        .overrun_cnt (overrun_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One-cycle data_update; the edge it consumes is the capture edge when idle.
    task automatic pulse(input logic signed [15:0] x, input logic signed [15:0] y,
                         input logic signed [15:0] z);
        data_x      = x;
        data_y      = y;
        data_z      = z;
        data_update = 1'b1;
        tick();
        data_update = 1'b0;
    endtask

    // Advance from edge 'start' until bcd_valid is seen; report the edge it followed.
    task automatic wait_valid(input int start, input int exp_edge, input string tag);
        int e;
        e = start;
        do begin
            tick();
            e++;
        end while (bcd_valid !== 1'b1 && e < exp_edge + 20);
        chk(tag, e, exp_edge);
    endtask

    task automatic count_valids(input int cycles, input string tag);
        int seen;
        seen = 0;
        for (int i = 0; i < cycles; i++) begin
            tick();
            if (bcd_valid === 1'b1) seen++;
        end
        chk(tag, seen, 0);
    endtask

    initial begin
        reset_n     = 1'b0;
        data_update = 1'b0;
        data_x      = '0;
        data_y      = '0;
        data_z      = '0;
        repeat (3) tick();

        chk("rst_bcd_x", bcd_x, 20'h0);
        chk("rst_neg_z", neg_z, 1'b0);
        chk("rst_valid", bcd_valid, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_ovr", overrun_cnt, 8'd0);

        reset_n = 1'b1;
        tick();

        // Basic sample
        pulse(16'sd1234, 16'sd0, -16'sd1);
        chk("busy_after_capture", busy, 1'b1);
        wait_valid(0, 55, "lat_basic");
        chk("basic_bcd_x", bcd_x, 20'h01234);
        chk("basic_neg_x", neg_x, 1'b0);
        chk("basic_bcd_y", bcd_y, 20'h00000);
        chk("basic_neg_y", neg_y, 1'b0);
        chk("basic_bcd_z", bcd_z, 20'h00001);
        chk("basic_neg_z", neg_z, 1'b1);
        tick();
        chk("basic_valid_one_cycle", bcd_valid, 1'b0);
        chk("basic_busy_low", busy, 1'b0);
        chk("basic_hold_x", bcd_x, 20'h01234);

        // Extremes
        pulse(16'sh8000, 16'sd32767, -16'sd32767);
        repeat (30) tick();
        chk("ext_hold_mid", bcd_x, 20'h01234);
        wait_valid(30, 55, "lat_ext");
        chk("ext_bcd_x", bcd_x, 20'h32768);
        chk("ext_neg_x", neg_x, 1'b1);
        chk("ext_bcd_y", bcd_y, 20'h32767);
        chk("ext_neg_y", neg_y, 1'b0);
        chk("ext_bcd_z", bcd_z, 20'h32767);
        chk("ext_neg_z", neg_z, 1'b1);
        tick();

        // Second sample arrives mid-conversion; it restarts on the idle cycle after DONE
        pulse(16'sd7, 16'sd8, 16'sd9);
        repeat (19) tick();
        pulse(16'sd5, 16'sd0, 16'sd0);
        wait_valid(20, 55, "lat_pend_first");
        chk("pend_first_x", bcd_x, 20'h00007);
        chk("pend_first_z", bcd_z, 20'h00009);
        wait_valid(55, 111, "lat_pend_second");
        chk("pend_second_x", bcd_x, 20'h00005);
        chk("pend_ovr", overrun_cnt, 8'd0);
        tick();

        // Three pulses: the middle one is overwritten in the pending buffer
        pulse(16'sd1, 16'sd0, 16'sd0);
        repeat (9) tick();
        pulse(16'sd2, 16'sd0, 16'sd0);
        repeat (9) tick();
        pulse(16'sd3, 16'sd0, 16'sd0);
        wait_valid(20, 55, "lat_ovr_first");
        chk("ovr_first_x", bcd_x, 20'h00001);
        chk("ovr_cnt_one", overrun_cnt, 8'd1);
        wait_valid(55, 111, "lat_ovr_second");
        chk("ovr_second_x", bcd_x, 20'h00003);
        count_valids(80, "ovr_no_third_result");
        chk("ovr_idle_busy", busy, 1'b0);

        // Async reset in the middle of a conversion
        pulse(16'sd4, 16'sd5, 16'sd6);
        repeat (30) tick();
        #2;
        reset_n = 1'b0;
        #1;
        chk("arst_bcd_x", bcd_x, 20'h0);
        chk("arst_busy", busy, 1'b0);
        chk("arst_ovr", overrun_cnt, 8'd0);
        chk("arst_valid", bcd_valid, 1'b0);
        repeat (3) tick();
        reset_n = 1'b1;
        count_valids(60, "arst_no_partial");
        pulse(-16'sd9, 16'sd42, 16'sd100);
        wait_valid(0, 55, "lat_after_rst");
        chk("after_rst_x", bcd_x, 20'h00009);
        chk("after_rst_neg_x", neg_x, 1'b1);
        chk("after_rst_y", bcd_y, 20'h00042);
        chk("after_rst_z", bcd_z, 20'h00100);
        tick();

        // Continuous updates: many dropped samples saturate the counter
        data_update = 1'b1;
        for (int i = 0; i < 400; i++) begin
            data_x = 16'(i);
            tick();
        end
        data_update = 1'b0;
        chk("sat_ovr", overrun_cnt, 8'd255);
        begin
            int n;
            n = 0;
            while (busy === 1'b1 && n < 200) begin
                tick();
                n++;
            end
            chk("sat_drain_busy", busy, 1'b0);
        end
        chk("sat_ovr_hold", overrun_cnt, 8'd255);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
